pi_sample_generator: RTL and testbench
======================================

# pi_sample_generator

Monte Carlo sample source and tally for the Pi estimator. Generates pseudo-random (x, y) points uniformly over the 480 x 480 quadrant and drives them to the external combinational point-in-circle checker. Accumulates the checker's inside/outside verdicts into total and inside counts. Sits between the control/display logic, which issues start and reads counts, and the circle checker.

## Interface
- COUNT_WIDTH, 32, width of sample target and counters
- COORD_LIMIT, 480, coordinates are accepted only if strictly less than this value
- SEED_X, 16'h0001, reset value of the X LFSR; a value of 0 is replaced by 1
- SEED_Y, 16'h0001, reset value of the Y LFSR; a value of 0 is replaced by 1
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a run; honoured only in IDLE or DONE
- sampleTarget  in  COUNT_WIDTH  number of accepted samples per run, latched on start
- xCoord  out  10  registered X coordinate to checker
- yCoord  out  10  registered Y coordinate to checker
- isInside  in  1  checker verdict for current xCoord/yCoord, combinational
- sampleValid  out  1  xCoord/yCoord hold an accepted sample this cycle
- totalCount  out  COUNT_WIDTH  accepted samples tallied this run
- insideCount  out  COUNT_WIDTH  accepted samples with isInside=1
- busy  out  1  high in RUN
- done  out  1  high in DONE, held until next start

## Operation
- Two 16-bit Galois LFSRs (X, Y): next = (s >> 1) ^ (s[0] ? 16'hB400 : 0). Step only in RUN, one step per cycle. State persists across runs and is reloaded only by reset.
- Candidate = low 10 bits of each LFSR's next state. Accepted iff both candidates < COORD_LIMIT and issued < target. Rejected candidates are discarded; sampleValid=0 the following cycle.
- `issued` (COUNT_WIDTH, internal) increments per accepted candidate. This stops over-issue.
- States:
  - IDLE: reset state.
  - IDLE/DONE + start: clear totalCount, insideCount, issued and sampleValid; latch target. Go to RUN, or to DONE if sampleTarget = 0.
  - RUN: each cycle, if sampleValid then totalCount += 1 and insideCount += isInside. Load xCoord/yCoord with the candidates. Set sampleValid to the acceptance result.
  - RUN -> DONE: on the cycle totalCount becomes target. sampleValid is cleared on the same edge.
  - DONE: counts frozen. xCoord/yCoord hold their last value.
- start while in RUN is ignored.
- No wrap: totalCount never exceeds target, so counters cannot overflow.
- isInside is ignored whenever sampleValid=0.

## Timing
- Reset (async, rstn=0):
  - state=IDLE, LFSRs=seeds
  - xCoord=0, yCoord=0, sampleValid=0
  - totalCount=0, insideCount=0, busy=0, done=0
- Start edge (cycle 0): busy=1 from cycle 1.
- Candidate registered on edge N is tallied on edge N+1. Two-cycle latency from LFSR step to count, with throughput of one sample per cycle.
- Minimum run: target + 1 cycles when no candidates are rejected. done rises on the edge that tallies the last sample.
- rstn deasserted mid-run: immediate return to reset values. The partial run is discarded.
- start and done coincident: the restart wins. done=0 and busy=1 the next cycle.

## Test plan
- Reset check: assert rstn=0 mid-activity -> all outputs are 0 immediately; first start after release reproduces the same coordinate sequence.
- Target 0: start with sampleTarget=0 -> done=1 one cycle later, busy never high, counts 0.
- Single sample, default seeds, target 1: first candidate is X=Y=0x000 (LFSR 0x0001->0xB400) -> xCoord=yCoord=0, sampleValid one cycle. With a real checker attached: totalCount=1, insideCount=1, done=1.
- Rejection: SEED_X=16'h0780, target 1 -> first X candidate 0x3C0=960 is rejected, sampleValid=0 that cycle. Run completes later with totalCount=1, and no tallied xCoord is ever >= 480.
- Statistical run, target 100000, real checker: done asserts; insideCount/totalCount within 0.7854 +/- 0.01; totalCount = 100000 exactly.
- Start pulsed during RUN ignored; start in DONE restarts -> counts clear, second run continues the LFSR sequence rather than repeating it.

Source files
------------

// File: rtl/pi_sample_generator.sv
// pi_sample_generator: Monte Carlo point source and tally for the Pi estimator.
// Two 16-bit Galois LFSRs produce (x, y) candidates over the 1024 x 1024 grid.
// Only candidates inside the COORD_LIMIT x COORD_LIMIT quadrant are presented
// to the external circle checker, and the verdicts are accumulated into
// totalCount / insideCount.
//
// Sample contract: sampleValid is a valid-only strobe with no back-pressure.
// While sampleValid=1, xCoord/yCoord hold an accepted point, and the
// combinational isInside verdict for that point is tallied on the next rising
// edge. When sampleValid=0, isInside is ignored.
module pi_sample_generator #(
    parameter int          COUNT_WIDTH = 32,
    parameter int          COORD_LIMIT = 480,
    parameter logic [15:0] SEED_X      = 16'h0001,
    parameter logic [15:0] SEED_Y      = 16'h0001
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] sampleTarget,
    output logic [9:0]             xCoord,
    output logic [9:0]             yCoord,
    input  logic                   isInside,
    output logic                   sampleValid,
    output logic [COUNT_WIDTH-1:0] totalCount,
    output logic [COUNT_WIDTH-1:0] insideCount,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             stateDbg
);

    // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [15:0] SEED_X_INIT = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;
    localparam logic [15:0] SEED_Y_INIT = (SEED_Y == 16'h0000) ? 16'h0001 : SEED_Y;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [10:0] COORD_LIM   = 11'(COORD_LIMIT);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic [15:0]            lfsrX;
    logic [15:0]            lfsrY;
    logic [15:0]            lfsrXNext;
    logic [15:0]            lfsrYNext;
    logic [9:0]             candX;
    logic [9:0]             candY;
    logic [COUNT_WIDTH-1:0] issued;
    logic [COUNT_WIDTH-1:0] targetReg;
    logic [COUNT_WIDTH-1:0] totalPlus;
    logic [COUNT_WIDTH-1:0] insidePlus;
    logic                   startTake;
    logic                   candInRange;
    logic                   accept;
    logic                   lastTally;

    // Galois step and candidate extraction; the candidate is the low 10 bits
    // of the state the LFSR is about to take.
    always_comb begin
        lfsrXNext   = (lfsrX >> 1) ^ (lfsrX[0] ? LFSR_TAPS : 16'h0000);
        lfsrYNext   = (lfsrY >> 1) ^ (lfsrY[0] ? LFSR_TAPS : 16'h0000);
        candX       = lfsrXNext[9:0];
        candY       = lfsrYNext[9:0];
        candInRange = ({1'b0, candX} < COORD_LIM) && ({1'b0, candY} < COORD_LIM);
        // Acceptance also stops once the run has issued its full target, so
        // the in-flight sample never pushes totalCount past the target.
        accept      = (state == RUN) && candInRange && (issued < targetReg);
        startTake   = start && (state != RUN);
        totalPlus   = totalCount + CNT_ONE;
        insidePlus  = insideCount + {{(COUNT_WIDTH-1){1'b0}}, isInside};
        lastTally   = (state == RUN) && sampleValid && (totalPlus == targetReg);
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: start is honoured only outside RUN; a zero target
    // finishes immediately.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext = (sampleTarget == CNT_ZERO) ? DONE : RUN;
                end
            end
            RUN: begin
                if (lastTally) begin
                    stateNext = DONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy     = (state == RUN);
        done     = (state == DONE);
        stateDbg = state;
    end

    // LFSRs advance once per RUN cycle and keep their state between runs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsrX <= SEED_X_INIT;
            lfsrY <= SEED_Y_INIT;
        end else if (state == RUN) begin
            lfsrX <= lfsrXNext;
            lfsrY <= lfsrYNext;
        end
    end

    // Sample pipeline and tally: a candidate registered on one edge is
    // counted on the following edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xCoord      <= 10'd0;
            yCoord      <= 10'd0;
            sampleValid <= 1'b0;
            totalCount  <= CNT_ZERO;
            insideCount <= CNT_ZERO;
            issued      <= CNT_ZERO;
            targetReg   <= CNT_ZERO;
        end else if (startTake) begin
            sampleValid <= 1'b0;
            totalCount  <= CNT_ZERO;
            insideCount <= CNT_ZERO;
            issued      <= CNT_ZERO;
            targetReg   <= sampleTarget;
        end else if (state == RUN) begin
            if (sampleValid) begin
                totalCount  <= totalPlus;
                insideCount <= insidePlus;
            end
            xCoord      <= candX;
            yCoord      <= candY;
            sampleValid <= accept;
            if (accept) begin
                issued <= issued + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pi_sample_generator.sv
// Directed bench for pi_sample_generator. Instance A uses the default seeds;
// instance B starts X at 16'h0780 so its first two X candidates fall outside
// the quadrant (960, then exactly 480). A behavioural circle checker
// (x^2 + y^2 < 480^2) drives isInside for both instances.
module tb_pi_sample_generator;

    localparam int CW = 32;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstnA, rstnB, startA, startB;
    logic [CW-1:0] targetA, targetB;
    logic [9:0]    xA, yA, xB, yB;
    logic          insideA, insideB, svA, svB, busyA, busyB, doneA, doneB;
    logic [CW-1:0] totA, insA, totB, insB;
    logic [1:0]    stateA, stateB;

    int            checkCount = 0;
    int            passCount  = 0;
    logic [9:0]    exp_q[$];
    logic [9:0]    obs_q[$];

    function automatic logic inCircle(input logic [9:0] x, input logic [9:0] y);
        int unsigned xi, yi;
        xi = {22'd0, x};
        yi = {22'd0, y};
        return (xi * xi + yi * yi) < 32'd230400;
    endfunction

    assign insideA = inCircle(xA, yA);
    assign insideB = inCircle(xB, yB);

    pi_sample_generator #(.COUNT_WIDTH(CW)) dutA (
        .clk(clk), .rstn(rstnA), .start(startA), .sampleTarget(targetA),
        .xCoord(xA), .yCoord(yA), .isInside(insideA), .sampleValid(svA),
        .totalCount(totA), .insideCount(insA), .busy(busyA), .done(doneA),
        .stateDbg(stateA)
    );

    pi_sample_generator #(.COUNT_WIDTH(CW), .SEED_X(16'h0780)) dutB (
        .clk(clk), .rstn(rstnB), .start(startB), .sampleTarget(targetB),
        .xCoord(xB), .yCoord(yB), .isInside(insideB), .sampleValid(svB),
        .totalCount(totB), .insideCount(insB), .busy(busyB), .done(doneB),
        .stateDbg(stateB)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic startRunA(input logic [CW-1:0] t);
        targetA = t;
        startA  = 1'b1;
        tick();
        startA  = 1'b0;
    endtask

    // Runs instance A until done (bounded), recording every valid sample.
    task automatic waitDoneA(input int budget, input int pulseAt, output int cycles,
                             output int nValid, output int nInside, output int nOver,
                             output bit timedOut);
        cycles = 0; nValid = 0; nInside = 0; nOver = 0; timedOut = 1'b1;
        obs_q.delete();
        for (int c = 0; c < budget; c++) begin
            if (c == pulseAt) startA = 1'b1;
            tick();
            startA = 1'b0;
            cycles++;
            if (svA) begin
                nValid++;
                if (insideA) nInside++;
                if (xA >= 10'd480 || yA >= 10'd480) nOver++;
                obs_q.push_back(xA);
            end
            if (doneA) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstnA = 1'b0; rstnB = 1'b0; startA = 1'b0; startB = 1'b0;
        targetA = '0; targetB = '0;
        #1;
        checkCount += 1;
        if ({xA, yA} !== 20'd0) $display("FAIL reset_coords: got %0d,%0d expected 0,0", xA, yA);
        else passCount += 1;
        checkCount += 1;
        if ({totA, insA} !== 64'd0) $display("FAIL reset_counts: got %0d,%0d expected 0,0", totA, insA);
        else passCount += 1;
        checkCount += 1;
        if ({svA, busyA, doneA, stateA} !== 5'd0) $display("FAIL reset_flags_a: got %b expected 00000", {svA, busyA, doneA, stateA});
        else passCount += 1;
        checkCount += 1;
        if ({svB, busyB, doneB, totB} !== 35'd0) $display("FAIL reset_flags_b: got %b/%0d expected 000/0", {svB, busyB, doneB}, totB);
        else passCount += 1;
        tick(); tick();
        #2;
        rstnA = 1'b1; rstnB = 1'b1;
        tick();
    endtask

    task automatic test_rejection;
        targetB = 1;
        startB  = 1'b1;
        tick();
        startB  = 1'b0;
        tick();
        checkCount += 1;
        if ({svB, busyB} !== 2'b01) $display("FAIL reject_960: got sv/busy %b expected 01", {svB, busyB});
        else passCount += 1;
        tick();
        checkCount += 1;
        if ({svB, busyB} !== 2'b01) $display("FAIL reject_480: got sv/busy %b expected 01", {svB, busyB});
        else passCount += 1;
        tick();
        checkCount += 1;
        if ({svB, xB, yB} !== {1'b1, 10'd240, 10'd256}) $display("FAIL accept_240: got sv=%b x=%0d y=%0d expected sv=1 x=240 y=256", svB, xB, yB);
        else passCount += 1;
        tick();
        checkCount += 1;
        if ({doneB, busyB, svB, totB, insB} !== {3'b100, 32'd1, 32'd1}) $display("FAIL reject_done: got done=%b tot=%0d ins=%0d expected done=1 tot=1 ins=1", doneB, totB, insB);
        else passCount += 1;
    endtask

    task automatic test_single_sample;
        startRunA(1);
        checkCount += 1;
        if ({busyA, doneA, svA, totA} !== {3'b100, 32'd0}) $display("FAIL single_start: got busy/done/sv %b tot=%0d expected 100 tot=0", {busyA, doneA, svA}, totA);
        else passCount += 1;
        tick();
        checkCount += 1;
        if ({svA, xA, yA} !== {1'b1, 10'd0, 10'd0}) $display("FAIL single_first_pt: got sv=%b x=%0d y=%0d expected 1,0,0", svA, xA, yA);
        else passCount += 1;
        tick();
        checkCount += 1;
        if ({doneA, busyA, svA, totA, insA} !== {3'b100, 32'd1, 32'd1}) $display("FAIL single_done: got done/busy/sv %b tot=%0d ins=%0d expected 100 1 1", {doneA, busyA, svA}, totA, insA);
        else passCount += 1;
    endtask

    task automatic test_start_in_run;
        int cycles, nValid, nInside, nOver;
        bit timedOut;
        startRunA(3);
        waitDoneA(100, 2, cycles, nValid, nInside, nOver, timedOut);
        exp_q = '{10'd256, 10'd416, 10'd360};
        checkCount += 1;
        if (timedOut || cycles != 7) $display("FAIL run3_cycles: got %0d (timeout=%0d) expected 7", cycles, timedOut);
        else passCount += 1;
        checkCount += 1;
        if (obs_q.size() != exp_q.size()) $display("FAIL run3_nsamples: got %0d expected %0d", obs_q.size(), exp_q.size());
        else passCount += 1;
        for (int i = 0; i < exp_q.size(); i++) begin
            checkCount += 1;
            if (obs_q[i] !== exp_q[i]) $display("FAIL run3_x%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]);
            else passCount += 1;
        end
        checkCount += 1;
        if ({totA, insA} !== {32'd3, 32'd1}) $display("FAIL run3_counts: got %0d/%0d expected 3/1", totA, insA);
        else passCount += 1;
    endtask

    task automatic test_restart_on_done;
        int cycles, nValid, nInside, nOver;
        bit timedOut;
        startRunA(2);
        checkCount += 1;
        if ({busyA, doneA, totA, insA} !== {2'b10, 32'd0, 32'd0}) $display("FAIL restart_clear: got busy/done %b tot=%0d ins=%0d expected 10 0 0", {busyA, doneA}, totA, insA);
        else passCount += 1;
        waitDoneA(100, -1, cycles, nValid, nInside, nOver, timedOut);
        exp_q = '{10'd90, 10'd45};
        checkCount += 1;
        if (timedOut || cycles != 3) $display("FAIL restart_cycles: got %0d (timeout=%0d) expected 3", cycles, timedOut);
        else passCount += 1;
        for (int i = 0; i < exp_q.size(); i++) begin
            checkCount += 1;
            if (obs_q[i] !== exp_q[i]) $display("FAIL restart_x%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]);
            else passCount += 1;
        end
        checkCount += 1;
        if ({totA, insA} !== {32'd2, 32'd2}) $display("FAIL restart_counts: got %0d/%0d expected 2/2", totA, insA);
        else passCount += 1;
    endtask

    task automatic test_target_zero;
        startRunA(0);
        checkCount += 1;
        if ({doneA, busyA, totA, insA} !== {2'b10, 32'd0, 32'd0}) $display("FAIL zero_done: got done/busy %b tot=%0d ins=%0d expected 10 0 0", {doneA, busyA}, totA, insA);
        else passCount += 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCount += 1;
            if ({doneA, busyA, svA} !== 3'b100) $display("FAIL zero_hold%0d: got done/busy/sv %b expected 100", i, {doneA, busyA, svA});
            else passCount += 1;
        end
    endtask

    task automatic test_reset_mid_run;
        int cycles, nValid, nInside, nOver;
        bit timedOut;
        startRunA(50);
        tick(); tick(); tick();
        #2;
        rstnA = 1'b0;
        #1;
        checkCount += 1;
        if ({xA, yA, svA, busyA, doneA, stateA} !== 25'd0) $display("FAIL midrst_outs: got x=%0d y=%0d flags=%b expected all 0", xA, yA, {svA, busyA, doneA, stateA});
        else passCount += 1;
        checkCount += 1;
        if ({totA, insA} !== 64'd0) $display("FAIL midrst_counts: got %0d/%0d expected 0/0", totA, insA);
        else passCount += 1;
        tick();
        #2;
        rstnA = 1'b1;
        tick();
        startRunA(2);
        waitDoneA(100, -1, cycles, nValid, nInside, nOver, timedOut);
        exp_q = '{10'd0, 10'd256};
        checkCount += 1;
        if (timedOut || cycles != 4) $display("FAIL midrst_cycles: got %0d (timeout=%0d) expected 4", cycles, timedOut);
        else passCount += 1;
        for (int i = 0; i < exp_q.size(); i++) begin
            checkCount += 1;
            if (obs_q[i] !== exp_q[i]) $display("FAIL midrst_x%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]);
            else passCount += 1;
        end
        checkCount += 1;
        if ({totA, insA} !== {32'd2, 32'd2}) $display("FAIL midrst_counts2: got %0d/%0d expected 2/2", totA, insA);
        else passCount += 1;
    endtask

    task automatic test_long_run;
        int cycles, nValid, nInside, nOver;
        bit timedOut;
        startRunA(200);
        waitDoneA(5000, -1, cycles, nValid, nInside, nOver, timedOut);
        checkCount += 1;
        if (timedOut) $display("FAIL long_timeout: got no done in %0d cycles expected done", cycles);
        else passCount += 1;
        checkCount += 1;
        if (totA !== 32'd200 || nValid != 200) $display("FAIL long_total: got tot=%0d seen=%0d expected 200/200", totA, nValid);
        else passCount += 1;
        checkCount += 1;
        if (insA !== CW'(nInside)) $display("FAIL long_inside: got %0d expected %0d", insA, nInside);
        else passCount += 1;
        checkCount += 1;
        if (nOver != 0) $display("FAIL long_range: got %0d out-of-range samples expected 0", nOver);
        else passCount += 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rejection();
        test_single_sample();
        test_start_in_run();
        test_restart_on_done();
        test_target_zero();
        test_reset_mid_run();
        test_long_run();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
